// File: rtl/flash_boot_copier.sv
`default_nettype none
// ============================================================================
// Module   : flash_boot_copier
// Brief    : Wishbone master copying WORDS words from boot flash to SDRAM while
//            holding the CPU in reset. Optional macro: FLASH_COPY_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module flash_boot_copier #(
    parameter logic [31:0] SRC_BASE   = 32'h1E00_0000,
    parameter logic [31:0] DST_BASE   = 32'h0000_0000,
    parameter int          WORDS      = 1024,
    parameter int          LEN_W      = 16,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        cpu_rst_o,
    output logic [31:0] checksum_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_RGAP  = 3'd2,
        S_WR    = 3'd3,
        S_WGAP  = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    localparam logic [LEN_W-1:0] c_LAST_IDX = LEN_W'(WORDS - 1);

    state_t            r_state, w_state_nxt;
    logic [LEN_W-1:0]  r_idx, w_idx_nxt;
    logic [31:0]       r_buf, w_buf_nxt;
    logic [31:0]       r_adr, w_adr_nxt;
    logic [31:0]       r_dat, w_dat_nxt;
    logic              r_cyc, w_cyc_nxt;
    logic              r_we, w_we_nxt;
    logic [3:0]        r_sel;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic              r_err, w_err_nxt;
    logic              r_cpu_rst, w_cpu_rst_nxt;
    logic              r_auto;
    logic              w_launch;

    function automatic logic [31:0] f_word_adr(input logic [31:0] base,
                                               input logic [LEN_W-1:0] idx);
        return base + (32'(idx) << 2);
    endfunction

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_buf_nxt     = r_buf;
        w_adr_nxt     = r_adr;
        w_dat_nxt     = r_dat;
        w_cyc_nxt     = r_cyc;
        w_we_nxt      = r_we;
        w_busy_nxt    = r_busy;
        w_done_nxt    = r_done;
        w_err_nxt     = r_err;
        w_cpu_rst_nxt = r_cpu_rst;
        w_launch      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_launch = start_i || r_auto;
            end
            S_RD: begin
                // err has priority over a simultaneous ack
                if (wbm_err_i) begin
                    w_state_nxt = S_ERROR;
                    w_cyc_nxt   = 1'b0;
                    w_we_nxt    = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_err_nxt   = 1'b1;
                end else if (wbm_ack_i) begin
                    w_state_nxt = S_RGAP;
                    w_buf_nxt   = wbm_dat_i;
                    w_cyc_nxt   = 1'b0;
                end
            end
            S_RGAP: begin
                w_state_nxt = S_WR;
                w_cyc_nxt   = 1'b1;
                w_we_nxt    = 1'b1;
                w_adr_nxt   = f_word_adr(DST_BASE, r_idx);
                w_dat_nxt   = r_buf;
            end
            S_WR: begin
                if (wbm_err_i) begin
                    w_state_nxt = S_ERROR;
                    w_cyc_nxt   = 1'b0;
                    w_we_nxt    = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_err_nxt   = 1'b1;
                end else if (wbm_ack_i) begin
                    w_state_nxt = S_WGAP;
                    w_cyc_nxt   = 1'b0;
                    w_we_nxt    = 1'b0;
                end
            end
            S_WGAP: begin
                if (r_idx == c_LAST_IDX) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_RD;
                    w_idx_nxt   = r_idx + 1'b1;
                    w_cyc_nxt   = 1'b1;
                    w_we_nxt    = 1'b0;
                    w_adr_nxt   = f_word_adr(SRC_BASE, r_idx + 1'b1);
                end
            end
            S_DONE: begin
                w_busy_nxt    = 1'b0;
                w_done_nxt    = 1'b1;
                w_cpu_rst_nxt = 1'b0;
                w_launch      = start_i;
            end
            S_ERROR: begin
                w_busy_nxt = 1'b0;
                w_err_nxt  = 1'b1;
                w_launch   = start_i;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // A (re)start overrides whatever the state above decided
        if (w_launch) begin
            w_idx_nxt     = '0;
            w_done_nxt    = 1'b0;
            w_err_nxt     = 1'b0;
            w_busy_nxt    = 1'b1;
            w_cpu_rst_nxt = 1'b1;
            if (WORDS == 0) begin
                w_state_nxt = S_DONE;
            end else begin
                w_state_nxt = S_RD;
                w_cyc_nxt   = 1'b1;
                w_we_nxt    = 1'b0;
                w_adr_nxt   = SRC_BASE;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_buf     <= 32'h0;
            r_adr     <= 32'h0;
            r_dat     <= 32'h0;
            r_cyc     <= 1'b0;
            r_we      <= 1'b0;
            r_sel     <= 4'h0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_cpu_rst <= 1'b1;
            r_auto    <= AUTO_START;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_buf     <= w_buf_nxt;
            r_adr     <= w_adr_nxt;
            r_dat     <= w_dat_nxt;
            r_cyc     <= w_cyc_nxt;
            r_we      <= w_we_nxt;
            r_sel     <= w_cyc_nxt ? 4'hF : 4'h0;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_cpu_rst <= w_cpu_rst_nxt;
            r_auto    <= 1'b0;
        end
    end

`ifdef FLASH_COPY_CHECKSUM_EN
    logic [31:0] r_checksum;
    logic        w_rd_ack;

    assign w_rd_ack = (r_state == S_RD) && wbm_ack_i && !wbm_err_i;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_checksum <= 32'h0;
        end else if (w_launch) begin
            r_checksum <= 32'h0;
        end else if (w_rd_ack) begin
            r_checksum <= r_checksum + wbm_dat_i;
        end
    end

    assign checksum_o = r_checksum;
`else
    assign checksum_o = 32'h0;
`endif

    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign err_o     = r_err;
    assign cpu_rst_o = r_cpu_rst;
    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_dat;
    assign wbm_sel_o = r_sel;
    assign wbm_we_o  = r_we;
    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_cyc;

endmodule
`default_nettype wire

// File: tb/tb_flash_boot_copier.sv
`default_nettype none
// ============================================================================
// Module   : tb_flash_boot_copier
// Brief    : Directed bench: Wishbone flash/SDRAM slave model, bus monitor and
//            a linear sequence of checks on flash_boot_copier.
// Revision : 1.0 - initial release
// ============================================================================
module tb_flash_boot_copier;

    localparam logic [31:0] c_SRC = 32'h1E00_0000;
    localparam logic [31:0] c_DST = 32'h0000_1000;
    localparam int          c_RLAT = 3;
    localparam int          c_WLAT = 1;
`ifdef FLASH_COPY_CHECKSUM_EN
    localparam bit c_CK = 1'b1;
`else
    localparam bit c_CK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, err, cpu_rst;
    logic [31:0] checksum, adr, dat_o;
    logic [31:0] dat_i = 32'h0;
    logic [3:0]  sel;
    logic        we, cyc, stb;
    logic        ack = 1'b0;
    logic        err_i = 1'b0;

    logic        busy2, done2, err2, cpu_rst2, we2, cyc2, stb2;
    logic [31:0] checksum2, adr2, dat_o2;
    logic [3:0]  sel2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    flash_boot_copier #(
        .SRC_BASE(c_SRC), .DST_BASE(c_DST), .WORDS(4), .LEN_W(16), .AUTO_START(1'b0)
    ) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .start_i(start),
        .busy_o(busy), .done_o(done), .err_o(err), .cpu_rst_o(cpu_rst),
        .checksum_o(checksum), .wbm_adr_o(adr), .wbm_dat_o(dat_o),
        .wbm_dat_i(dat_i), .wbm_sel_o(sel), .wbm_we_o(we), .wbm_cyc_o(cyc),
        .wbm_stb_o(stb), .wbm_ack_i(ack), .wbm_err_i(err_i)
    );

    flash_boot_copier #(
        .SRC_BASE(c_SRC), .DST_BASE(c_DST), .WORDS(0), .LEN_W(16), .AUTO_START(1'b1)
    ) dut_zero (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .start_i(1'b0),
        .busy_o(busy2), .done_o(done2), .err_o(err2), .cpu_rst_o(cpu_rst2),
        .checksum_o(checksum2), .wbm_adr_o(adr2), .wbm_dat_o(dat_o2),
        .wbm_dat_i(32'h0), .wbm_sel_o(sel2), .wbm_we_o(we2), .wbm_cyc_o(cyc2),
        .wbm_stb_o(stb2), .wbm_ack_i(1'b0), .wbm_err_i(1'b0)
    );

    // ---------------- slave model: flash at c_SRC, SDRAM at c_DST ----------------
    logic [31:0] flash [4];
    logic [31:0] sdram [4];
    logic        inject_err = 1'b0;
    int          s_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_cnt <= 0;
            ack   <= 1'b0;
            err_i <= 1'b0;
        end else if (cyc && !ack && !err_i) begin
            if (s_cnt + 1 >= (we ? c_WLAT : c_RLAT)) begin
                s_cnt <= 0;
                if (!we && inject_err && adr == c_SRC + 32'd8) begin
                    err_i <= 1'b1;
                end else begin
                    ack <= 1'b1;
                    if (!we) dat_i <= flash[2'((adr - c_SRC) >> 2)];
                    else     sdram[2'((adr - c_DST) >> 2)] <= dat_o;
                end
            end else begin
                s_cnt <= s_cnt + 1;
            end
        end else begin
            ack   <= 1'b0;
            err_i <= 1'b0;
            s_cnt <= 0;
        end
    end

    // ---------------- bus monitor ----------------
    logic [31:0] log_adr [$];
    logic [31:0] log_dat [$];
    logic        log_we  [$];
    int          viol = 0;
    int          err_seen = 0;
    bit          prev_end = 1'b0;
    bit          cyc2_seen = 1'b0;

    always @(negedge clk) begin
        if (cyc !== stb) viol++;
        if (cyc && (sel !== 4'hF || adr[1:0] !== 2'b00)) viol++;
        if (!cyc && sel !== 4'h0) viol++;
        if (prev_end && cyc) viol++;
        prev_end = cyc && (ack || err_i);
        if (cyc && err_i) err_seen++;
        if (cyc && ack && !err_i) begin
            log_adr.push_back(adr);
            log_we.push_back(we);
            log_dat.push_back(we ? dat_o : dat_i);
        end
        if (cyc2) cyc2_seen = 1'b1;
    end

    // ---------------- helpers ----------------
    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check32({tag, " cyc"},      {31'h0, cyc},     32'h0);
        check32({tag, " stb"},      {31'h0, stb},     32'h0);
        check32({tag, " we"},       {31'h0, we},      32'h0);
        check32({tag, " adr"},      adr,              32'h0);
        check32({tag, " dat_o"},    dat_o,            32'h0);
        check32({tag, " sel"},      {28'h0, sel},     32'h0);
        check32({tag, " busy"},     {31'h0, busy},    32'h0);
        check32({tag, " done"},     {31'h0, done},    32'h0);
        check32({tag, " err"},      {31'h0, err},     32'h0);
        check32({tag, " cpu_rst"},  {31'h0, cpu_rst}, 32'h1);
        check32({tag, " checksum"}, checksum,         32'h0);
    endtask

    // Start pulse: returns at the negedge after the edge that sampled start.
    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic run_until_idle(output int n);
        n = -1;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (!busy) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic check_copy_log(input string tag, input int base, input logic [31:0] v [4]);
        check32({tag, " log size"}, 32'(log_adr.size() - base), 32'd8);
        if (log_adr.size() - base == 8) begin
            for (int k = 0; k < 4; k++) begin
                check32($sformatf("%s R%0d adr", tag, k), log_adr[base + 2*k], c_SRC + 32'(4*k));
                check32($sformatf("%s R%0d we", tag, k), {31'h0, log_we[base + 2*k]}, 32'h0);
                check32($sformatf("%s W%0d adr", tag, k), log_adr[base + 2*k + 1], c_DST + 32'(4*k));
                check32($sformatf("%s W%0d dat", tag, k), log_dat[base + 2*k + 1], v[k]);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int          n;
        int          base;
        int          bad;
        int          dst8;
        logic [31:0] v [4];

        flash[0] = 32'h1; flash[1] = 32'h2; flash[2] = 32'h3; flash[3] = 32'h4;

        // reset state
        #23;
        check_reset_vals("reset");
        check32("zero cpu_rst in reset", {31'h0, cpu_rst2}, 32'h1);

        // T5: WORDS=0 auto start, done two edges after release
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check32("T5 busy e1", {31'h0, busy2}, 32'h1);
        check32("T5 done e1", {31'h0, done2}, 32'h0);
        @(negedge clk);
        check32("T5 done e2",    {31'h0, done2},    32'h1);
        check32("T5 cpu_rst e2", {31'h0, cpu_rst2}, 32'h0);
        check32("T5 busy e2",    {31'h0, busy2},    32'h0);
        check32("idle no auto",  {31'h0, busy | cyc}, 32'h0);

        // T1/T2: full copy
        base = log_adr.size();
        pulse_start();
        check32("T1 first cyc", {31'h0, cyc}, 32'h1);
        check32("T1 first adr", adr, c_SRC);
        check32("T1 first we",  {31'h0, we}, 32'h0);
        bad = 0;
        n = -1;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (done !== !cpu_rst) bad++;
            if (!busy) begin
                n = i;
                break;
            end
        end
        check32("T1 cycles", 32'(n), 32'd33);
        check32("T1 done/cpu_rst same edge", 32'(bad), 32'd0);
        check32("T1 done", {31'h0, done}, 32'h1);
        check32("T1 err",  {31'h0, err},  32'h0);
        v[0] = 32'h1; v[1] = 32'h2; v[2] = 32'h3; v[3] = 32'h4;
        check_copy_log("T1", base, v);
        for (int k = 0; k < 4; k++) check32($sformatf("T1 dst%0d", k), sdram[k], v[k]);
        check32("T1 checksum", checksum, c_CK ? 32'd10 : 32'd0);
        check32("T2 bus rules", 32'(viol), 32'd0);

        // T3: error on read of idx 2, restart from DONE
        inject_err = 1'b1;
        base = log_adr.size();
        pulse_start();
        check32("T3 restart cpu_rst", {31'h0, cpu_rst}, 32'h1);
        check32("T3 restart done",    {31'h0, done},    32'h0);
        run_until_idle(n);
        check32("T3 terminated", {31'h0, n > 0}, 32'h1);
        check32("T3 err",     {31'h0, err},     32'h1);
        check32("T3 done",    {31'h0, done},    32'h0);
        check32("T3 cpu_rst", {31'h0, cpu_rst}, 32'h1);
        check32("T3 cyc",     {31'h0, cyc},     32'h0);
        check32("T3 err cycles", 32'(err_seen), 32'd1);
        check32("T3 log size", 32'(log_adr.size() - base), 32'd4);
        dst8 = 0;
        for (int k = base; k < log_adr.size(); k++)
            if (log_we[k] && log_adr[k] == c_DST + 32'd8) dst8++;
        check32("T3 no write DST+8", 32'(dst8), 32'd0);
        check32("T3 checksum held", checksum, c_CK ? 32'd3 : 32'd0);
        inject_err = 1'b0;

        // T4: reset during W1, then a clean full copy
        pulse_start();
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            if (cyc && we && adr == c_DST + 32'd4) begin
                n = i;
                break;
            end
            @(negedge clk);
        end
        check32("T4 reached W1", {31'h0, n > 0}, 32'h1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("T4 async");
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check32("T4 stays idle", {31'h0, busy}, 32'h0);
        base = log_adr.size();
        pulse_start();
        run_until_idle(n);
        check32("T4 cycles", 32'(n), 32'd33);
        check32("T4 done", {31'h0, done}, 32'h1);
        check_copy_log("T4", base, v);
        for (int k = 0; k < 4; k++) check32($sformatf("T4 dst%0d", k), sdram[k], v[k]);

        // T6: checksum wrap, plus a start pulse while busy that must be ignored
        flash[0] = 32'hFFFF_FFFF; flash[1] = 32'h2; flash[2] = 32'h0; flash[3] = 32'h0;
        v[0] = 32'hFFFF_FFFF; v[1] = 32'h2; v[2] = 32'h0; v[3] = 32'h0;
        base = log_adr.size();
        pulse_start();
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        run_until_idle(n);
        check32("T6 cycles", 32'(n + 11), 32'd33);
        check_copy_log("T6", base, v);
        check32("T6 checksum", checksum, c_CK ? 32'h1 : 32'h0);
        check32("T6 done", {31'h0, done}, 32'h1);
        check32("T2 bus rules all", 32'(viol), 32'd0);
        check32("T5 no cyc", {31'h0, cyc2_seen}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
